// File: rtl/line_buf_sched_pkg.sv
// Shared types and constants for the camera line buffer scheduler.
package cnn_sched_pkg;

  // Read-side sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // Bit positions of the two readers in the request / grant vectors
  localparam int REQ_CPU = 0;
  localparam int REQ_LCD = 1;

  // Lines-read-since-frame-start counter, wraps naturally at 4095
  localparam int LINE_IDX_W = 12;
  typedef logic [LINE_IDX_W-1:0] line_cnt_t;

endpackage

// File: rtl/line_buf_sched_rr_arb2.sv
// Two-way round-robin arbiter for the shared FIFO read port.
// The last-grant record only moves when a whole line has been read,
// so fairness is per line rather than per word.
import cnn_sched_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic [1:0] gnt,
  output logic [1:0] win
);

  logic last_lcd;

  // Remember who owned the line that just finished; LCD after reset so the CPU wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_lcd <= 1'b1;
    end else if (done) begin
      last_lcd <= gnt[REQ_LCD];
    end
  end

  // A lone requester wins outright; on a tie the side not served last wins
  always_comb begin
    win = req;
    if (req[REQ_CPU] && req[REQ_LCD]) begin
      win = 2'b00;
      if (last_lcd) begin
        win[REQ_CPU] = 1'b1;
      end else begin
        win[REQ_LCD] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_buf_sched.sv
// Ping-pong line buffer scheduler: picks the write FIFO per camera line,
// blocks the producer when both lines are pending, and hands complete
// lines to the CPU or LCD reader one whole line at a time.
// Optional watchdog abort of a stalled read: define LINE_TIMEOUT_EN.
import cnn_sched_pkg::*;

module line_buf_sched #(
  parameter int LINE_WORDS = 640,
  parameter int CNT_W      = $clog2(LINE_WORDS + 1),
  parameter int TMO_CYC    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_start,
  input  logic        i_line_done,
  output logic        o_wr_sel,
  output logic        o_wr_allow,
  output logic [15:0] o_drop_cnt,
  input  logic [1:0]  i_fifo_empty,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_rd_ready,
  output logic [1:0]  o_gnt,
  output logic        o_rd_en,
  output logic        o_rd_sel,
  output logic        o_line_rd_done,
  output logic [11:0] o_line_idx,
  output logic        o_line_rdy,
  output logic        o_timeout
);

  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_WORDS);

  // A line must fit in one FIFO and the watchdog needs a sensible limit
  if (LINE_WORDS < 1 || LINE_WORDS > 1024 || TMO_CYC < 2) begin : g_bad_cfg
    $error("line_buf_sched: LINE_WORDS must be 1..1024 and TMO_CYC at least 2");
  end

  sched_state_e     state, state_next;
  logic [1:0]       full, full_next;
  logic             wr_sel, wr_sel_next;
  logic             rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic [1:0]       win;
  logic [15:0]      drop_cnt;
  line_cnt_t        line_idx;
  logic             line_rdy;
  logic             wr_allow;
  logic             owner;
  logic             rd_en;
  logic             rd_owned;
  logic             start;
  logic             rel;
  logic             tmo_fire;

  assign wr_allow = ~full[wr_sel];
  assign owner    = gnt[REQ_LCD];
  assign rd_owned = (state == READ) || (state == DONE);
  assign rd_en    = (state == READ) & i_rd_ready[owner] & ~i_fifo_empty[rd_ptr] & (cnt < LINE_LAST);
  assign rel      = (state == DONE) | tmo_fire;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (i_req),
    .done  (state == DONE),
    .gnt   (gnt),
    .win   (win)
  );

`ifdef LINE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC);
  logic [TMO_W-1:0] tmo_cnt;

  // Count consecutive READ cycles without a pop; any pop or leaving READ restarts it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != READ || rd_en) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_fire = (state == READ) & ~rd_en & (cnt != LINE_LAST) & (tmo_cnt == TMO_W'(TMO_CYC - 1));
`else
  assign tmo_fire = 1'b0;
`endif

  // Read FSM: wait for a complete line plus a requester, hold the grant for the whole line
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_ptr] && (|i_req) && !i_frame_start) begin
          state_next = GRANT;
          start      = 1'b1;
        end
      end
      GRANT: state_next = READ;
      READ: begin
        if (cnt == LINE_LAST) begin
          state_next = DONE;
        end else if (tmo_fire) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer occupancy: producer sets, reader / frame start clear; a clear wins on its own buffer
  always_comb begin
    full_next = full;
    if (i_line_done && wr_allow) begin
      full_next[wr_sel] = 1'b1;
    end
    if (i_frame_start) begin
      for (int b = 0; b < 2; b++) begin
        if (!(rd_owned && (rd_ptr == 1'(b)))) begin
          full_next[b] = 1'b0;
        end
      end
    end
    if (rel) begin
      full_next[rd_ptr] = 1'b0;
    end
  end

  // Write select: ping-pong after each line, park when both are full, jump to a freed buffer
  always_comb begin
    wr_sel_next = wr_sel;
    if (i_frame_start) begin
      wr_sel_next = (state == IDLE) ? 1'b0 : ~rd_ptr;
    end else if (i_line_done && wr_allow && !full[~wr_sel]) begin
      wr_sel_next = ~wr_sel;
    end else if (rel && (full[wr_sel] || (i_line_done && wr_allow))) begin
      wr_sel_next = rd_ptr;
    end
  end

  // State, occupancy and write-select registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      full     <= 2'b00;
      wr_sel   <= 1'b0;
      line_rdy <= 1'b0;
    end else begin
      state    <= state_next;
      full     <= full_next;
      wr_sel   <= wr_sel_next;
      line_rdy <= |full_next;
    end
  end

  // Read pointer, word counter and held grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      cnt    <= '0;
      gnt    <= 2'b00;
    end else begin
      if (i_frame_start && state == IDLE) begin
        rd_ptr <= 1'b0;
      end else if (rel) begin
        rd_ptr <= ~rd_ptr;
      end

      if (rel) begin
        cnt <= '0;
      end else if (rd_en) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (start) begin
        gnt <= win;
      end else if (rel) begin
        gnt <= 2'b00;
      end
    end
  end

  // Dropped-line and lines-read counters; drops survive frame start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= 16'h0000;
      line_idx <= '0;
    end else begin
      if (i_line_done && !wr_allow && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'h0001;
      end

      if (i_frame_start) begin
        line_idx <= '0;
      end else if (state == DONE) begin
        line_idx <= line_idx + line_cnt_t'(1);
      end
    end
  end

  assign o_wr_sel       = wr_sel;
  assign o_wr_allow     = wr_allow;
  assign o_drop_cnt     = drop_cnt;
  assign o_gnt          = gnt;
  assign o_rd_en        = rd_en;
  assign o_rd_sel       = rd_ptr;
  assign o_line_rd_done = (state == DONE);
  assign o_line_idx     = line_idx;
  assign o_line_rdy     = line_rdy;
  assign o_timeout      = tmo_fire;

endmodule

// File: tb/tb_line_buf_sched.sv
// Directed bench for line_buf_sched with LINE_WORDS=8 and TMO_CYC=16.
module tb_line_buf_sched;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_frame_start;
  logic        i_line_done;
  logic        o_wr_sel;
  logic        o_wr_allow;
  logic [15:0] o_drop_cnt;
  logic [1:0]  i_fifo_empty;
  logic [1:0]  i_req;
  logic [1:0]  i_rd_ready;
  logic [1:0]  o_gnt;
  logic        o_rd_en;
  logic        o_rd_sel;
  logic        o_line_rd_done;
  logic [11:0] o_line_idx;
  logic        o_line_rdy;
  logic        o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  line_buf_sched #(.LINE_WORDS(LW), .TMO_CYC(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_frame_start  (i_frame_start),
    .i_line_done    (i_line_done),
    .o_wr_sel       (o_wr_sel),
    .o_wr_allow     (o_wr_allow),
    .o_drop_cnt     (o_drop_cnt),
    .i_fifo_empty   (i_fifo_empty),
    .i_req          (i_req),
    .i_rd_ready     (i_rd_ready),
    .o_gnt          (o_gnt),
    .o_rd_en        (o_rd_en),
    .o_rd_sel       (o_rd_sel),
    .o_line_rd_done (o_line_rd_done),
    .o_line_idx     (o_line_idx),
    .o_line_rdy     (o_line_rdy),
    .o_timeout      (o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fs;
    logic        ld;
    logic        exp_wr_sel;
    logic        exp_wr_allow;
    logic [15:0] exp_drop;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_frame_start = v.fs;
    i_line_done   = v.ld;
    @(posedge clk);
    #1;
    i_frame_start = 1'b0;
    i_line_done   = 1'b0;
  endtask

  task automatic applyVector(input int i);
    applyStimulus(vecs[i]);
    checkOutput($sformatf("vec%0d wr_sel", i), 16'(o_wr_sel), 16'(vecs[i].exp_wr_sel));
    checkOutput($sformatf("vec%0d wr_allow", i), 16'(o_wr_allow), 16'(vecs[i].exp_wr_allow));
    checkOutput($sformatf("vec%0d drop_cnt", i), o_drop_cnt, vecs[i].exp_drop);
    checkOutput($sformatf("vec%0d line_rdy", i), 16'(o_line_rdy), 16'(vecs[i].exp_rdy));
    checkOutput($sformatf("vec%0d gnt", i), 16'(o_gnt), 16'h0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    i_frame_start = 1'b0;
    i_line_done = 1'b0;
    i_fifo_empty = 2'b00;
    i_req = 2'b00;
    i_rd_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulseLineDone();
    i_line_done = 1'b1;
    @(posedge clk);
    #1;
    i_line_done = 1'b0;
  endtask

  // Drive one line read to completion, sampling outputs mid-cycle
  task automatic runRead(input logic [1:0] rq, input bit toggle_rdy, input int empty_start,
                         input bit drop_req, input int fs_at, input logic exp_sel,
                         output int pops, output logic [1:0] gnt_seen, output int bad_sel,
                         output int bad_en, output bit done_seen, output logic [11:0] idx_after_fs);
    pops = 0;
    gnt_seen = 2'b00;
    bad_sel = 0;
    bad_en = 0;
    done_seen = 1'b0;
    idx_after_fs = '0;
    i_req = rq;
    for (int k = 0; k < 200 && !done_seen; k++) begin
      @(posedge clk);
      #1;
      i_rd_ready    = (toggle_rdy && (k % 2 == 1)) ? 2'b00 : 2'b11;
      i_fifo_empty  = (k >= empty_start && k < empty_start + 3) ? 2'b11 : 2'b00;
      i_frame_start = (k == fs_at);
      if (k == fs_at + 1) idx_after_fs = o_line_idx;
      #1;
      if (o_gnt != 2'b00 && gnt_seen == 2'b00) begin
        gnt_seen = o_gnt;
        if (drop_req) i_req = 2'b00;
      end
      if (o_rd_en) begin
        pops++;
        if (o_rd_sel !== exp_sel) bad_sel++;
        if (i_rd_ready != 2'b11 || i_fifo_empty != 2'b00) bad_en++;
      end
      if (o_line_rd_done) done_seen = 1'b1;
    end
    i_frame_start = 1'b0;
    i_rd_ready = 2'b11;
    i_fifo_empty = 2'b00;
  endtask

  task automatic checkRead(input string tag, input int pops, input logic [1:0] gnt_seen,
                           input logic [1:0] exp_gnt, input int bad_sel, input int bad_en,
                           input bit done_seen);
    checkOutput({tag, " pops"}, 16'(pops), 16'(LW));
    checkOutput({tag, " gnt"}, 16'(gnt_seen), 16'(exp_gnt));
    checkOutput({tag, " rd_sel errors"}, 16'(bad_sel), 16'h0);
    checkOutput({tag, " illegal rd_en"}, 16'(bad_en), 16'h0);
    checkOutput({tag, " line_rd_done"}, 16'(done_seen), 16'h1);
  endtask

  initial begin
    int pops, bad_sel, bad_en;
    logic [1:0] gseen;
    bit dseen;
    logic [11:0] idx_fs;

    //            fs    ld    sel   allow drop   rdy
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1};

    $display("[TB] reset state");
    doReset();
    checkOutput("reset wr_allow", 16'(o_wr_allow), 16'h1);
    checkOutput("reset wr_sel", 16'(o_wr_sel), 16'h0);
    checkOutput("reset gnt", 16'(o_gnt), 16'h0);
    checkOutput("reset rd_en", 16'(o_rd_en), 16'h0);
    checkOutput("reset rd_sel", 16'(o_rd_sel), 16'h0);
    checkOutput("reset line_rd_done", 16'(o_line_rd_done), 16'h0);
    checkOutput("reset line_idx", 16'(o_line_idx), 16'h0);
    checkOutput("reset line_rdy", 16'(o_line_rdy), 16'h0);
    checkOutput("reset drop_cnt", o_drop_cnt, 16'h0);
    checkOutput("reset timeout", 16'(o_timeout), 16'h0);

    $display("[TB] overflow with no reader");
    for (int i = 0; i < 6; i++) applyVector(i);
    runRead(2'b01, 1'b0, -100, 1'b0, -1, 1'b0, pops, gseen, bad_sel, bad_en, dseen, idx_fs);
    checkRead("overflow read", pops, gseen, 2'b01, bad_sel, bad_en, dseen);
    @(posedge clk); #1;
    i_req = 2'b00;
    checkOutput("overflow wr_allow back", 16'(o_wr_allow), 16'h1);
    checkOutput("overflow wr_sel freed", 16'(o_wr_sel), 16'h0);
    checkOutput("overflow line_idx", 16'(o_line_idx), 16'h1);
    checkOutput("overflow line_rdy", 16'(o_line_rdy), 16'h1);
    $display("[TB] frame start keeps drop count");
    for (int i = 6; i < 8; i++) applyVector(i);

    $display("[TB] single line, CPU only");
    doReset();
    pulseLineDone();
    runRead(2'b01, 1'b0, -100, 1'b0, -1, 1'b0, pops, gseen, bad_sel, bad_en, dseen, idx_fs);
    checkRead("single", pops, gseen, 2'b01, bad_sel, bad_en, dseen);
    @(posedge clk); #1;
    i_req = 2'b00;
    checkOutput("single line_idx", 16'(o_line_idx), 16'h1);
    checkOutput("single wr_sel", 16'(o_wr_sel), 16'h1);
    checkOutput("single gnt released", 16'(o_gnt), 16'h0);
    checkOutput("single line_rdy", 16'(o_line_rdy), 16'h0);

    $display("[TB] tie after reset");
    doReset();
    pulseLineDone();
    pulseLineDone();
    runRead(2'b11, 1'b0, -100, 1'b0, -1, 1'b0, pops, gseen, bad_sel, bad_en, dseen, idx_fs);
    checkRead("tie first", pops, gseen, 2'b01, bad_sel, bad_en, dseen);
    runRead(2'b11, 1'b0, -100, 1'b0, -1, 1'b1, pops, gseen, bad_sel, bad_en, dseen, idx_fs);
    checkRead("tie second", pops, gseen, 2'b10, bad_sel, bad_en, dseen);
    @(posedge clk); #1;
    i_req = 2'b00;
    checkOutput("tie line_idx", 16'(o_line_idx), 16'h2);
    checkOutput("tie wr_sel", 16'(o_wr_sel), 16'h0);
    checkOutput("tie line_rdy", 16'(o_line_rdy), 16'h0);

    $display("[TB] back-pressure and empty stall");
    doReset();
    pulseLineDone();
    runRead(2'b10, 1'b1, 2, 1'b1, -1, 1'b0, pops, gseen, bad_sel, bad_en, dseen, idx_fs);
    checkRead("backpressure", pops, gseen, 2'b10, bad_sel, bad_en, dseen);
    @(posedge clk); #1;
    checkOutput("backpressure line_idx", 16'(o_line_idx), 16'h1);

    $display("[TB] frame start during READ");
    doReset();
    pulseLineDone();
    pulseLineDone();
    runRead(2'b01, 1'b0, -100, 1'b0, -1, 1'b0, pops, gseen, bad_sel, bad_en, dseen, idx_fs);
    @(posedge clk); #1;
    i_req = 2'b00;
    checkOutput("frame pre line_idx", 16'(o_line_idx), 16'h1);
    pulseLineDone();
    checkOutput("frame pre wr_allow", 16'(o_wr_allow), 16'h0);
    runRead(2'b01, 1'b0, -100, 1'b0, 4, 1'b1, pops, gseen, bad_sel, bad_en, dseen, idx_fs);
    checkRead("frame line", pops, gseen, 2'b01, bad_sel, bad_en, dseen);
    checkOutput("frame idx after start", 16'(idx_fs), 16'h0);
    @(posedge clk); #1;
    i_req = 2'b00;
    checkOutput("frame idx after line", 16'(o_line_idx), 16'h1);
    checkOutput("frame both cleared", 16'(o_line_rdy), 16'h0);
    checkOutput("frame wr_sel", 16'(o_wr_sel), 16'h0);
    checkOutput("frame wr_allow", 16'(o_wr_allow), 16'h1);

    doReset();
    pulseLineDone();
    i_req = 2'b01;
    i_rd_ready = 2'b00;
`ifdef LINE_TIMEOUT_EN
    begin
      int kg, kt, ntmo, ndone;
      $display("[TB] watchdog abort");
      kg = -1; kt = -1; ntmo = 0; ndone = 0;
      for (int k = 0; k < 60; k++) begin
        @(posedge clk); #1;
        if (o_gnt != 2'b00 && kg < 0) kg = k;
        if (o_timeout) begin kt = k; ntmo++; end
        if (o_line_rd_done) ndone++;
      end
      checkOutput("tmo pulses", 16'(ntmo), 16'h1);
      checkOutput("tmo latency", 16'(kt - kg), 16'd16);
      checkOutput("tmo no done", 16'(ndone), 16'h0);
      checkOutput("tmo gnt released", 16'(o_gnt), 16'h0);
      checkOutput("tmo line_idx", 16'(o_line_idx), 16'h0);
      checkOutput("tmo line_rdy", 16'(o_line_rdy), 16'h0);
    end
`else
    begin
      int ntmo;
      $display("[TB] stalled read waits");
      ntmo = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (o_timeout || o_line_rd_done) ntmo++;
      end
      checkOutput("stall no abort", 16'(ntmo), 16'h0);
      checkOutput("stall gnt held", 16'(o_gnt), 16'h1);
      checkOutput("stall line_rdy", 16'(o_line_rdy), 16'h1);
    end
`endif
    i_req = 2'b00;
    i_rd_ready = 2'b11;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buf_sched.md
Name: line_buf_sched

Overview:
- Sequences the two camera line FIFOs (ping-pong pair, 16-bit, 1024 deep) between one producer (camera receive path) and two readers: the AXI slave (CPU) and the LCD path.
- Selects the write buffer per line and blocks the producer when both buffers are full.
- Arbitrates the shared read port round-robin, with the grant held for one whole line.
- Sits in cnn_top between the camera receiver, both async FIFOs' read side, the AXI slave and rgb_top. All ports are in the clk domain; the caller synchronises camera events beforehand.

Parameters:
- LINE_WORDS, 640, 16-bit words per line; must be ≤ FIFO depth (1024).
- CNT_W, $clog2(LINE_WORDS+1), width of the read word counter.
- TMO_CYC, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_frame_start  in  1  one-cycle pulse at start of frame
- i_line_done  in  1  one-cycle pulse: producer finished a line
- o_wr_sel  out  1  write buffer select (0 = fifo1, 1 = fifo2)
- o_wr_allow  out  1  producer may write; gates the FIFO wr_en
- o_drop_cnt  out  16  lines dropped while blocked, saturating
- i_fifo_empty  in  2  empty flags of fifo1/fifo2
- i_req  in  2  read requests; bit0 = CPU, bit1 = LCD
- i_rd_ready  in  2  granted requester can accept a word
- o_gnt  out  2  one-hot grant
- o_rd_en  out  1  FIFO pop strobe
- o_rd_sel  out  1  FIFO being read
- o_line_rd_done  out  1  one-cycle pulse: line fully read
- o_line_idx  out  12  lines read since frame start
- o_line_rdy  out  1  some buffer holds a complete unread line
- o_timeout  out  1  one-cycle watchdog abort pulse (0 when feature is off)

Behaviour:
- Reset (rst_n=0 at a clk edge): every output is 0 except o_wr_allow=1. Internal state:
  - full[1:0]=0, rd_ptr=0, FSM=IDLE, word counter=0, round-robin last-grant=LCD, so the CPU wins the first tie.
  - Reset mid-line aborts everything; no done pulse is issued.
- Write side:
  - o_wr_allow = ~full[o_wr_sel].
  - On i_line_done with o_wr_allow=1:
    - Set full[wr_sel].
    - If full[~wr_sel]=0, toggle wr_sel in the same cycle. Otherwise keep wr_sel, so o_wr_allow drops the next cycle.
  - On i_line_done with o_wr_allow=0: o_drop_cnt += 1, saturating at 16'hFFFF.
  - When the reader frees a buffer while blocked, toggle wr_sel onto the freed buffer; o_wr_allow returns the next cycle.
- Read FSM states: IDLE, GRANT, READ, DONE.
  - IDLE → GRANT: when full[rd_ptr] & |i_req.
    - Pick the winner: a single requester wins outright; on a tie, the one not granted last wins.
    - Register o_gnt; o_gnt is valid one cycle after the request is seen.
  - GRANT → READ: next cycle.
  - READ:
    - o_rd_sel = rd_ptr.
    - o_rd_en = i_rd_ready[owner] & ~i_fifo_empty[rd_ptr] & (cnt < LINE_WORDS), combinational from registered state.
    - Each pop increments cnt.
    - cnt == LINE_WORDS → DONE.
    - Deasserting i_req mid-line is ignored; the grant is held until the line completes.
  - DONE (1 cycle):
    - Pulse o_line_rd_done; clear full[rd_ptr]; toggle rd_ptr; cnt=0; o_gnt=0; o_line_idx += 1, wrapping at 4095.
    - Update the last-grant record → IDLE.
  - The same-cycle i_line_done and buffer clear are both applied; the clear takes precedence only for the buffer being cleared.
- o_line_rdy = |full (registered).
- i_frame_start:
  - o_line_idx=0; o_drop_cnt is not cleared.
  - Any full buffer not currently owned by READ/DONE is cleared.
  - If the FSM is idle, wr_sel=0 and rd_ptr=0. Otherwise wr_sel = ~rd_ptr, and the current line completes normally.

Optional Feature:
- Macro LINE_TIMEOUT_EN.
  - Defined: in READ, count consecutive cycles with no pop. On reaching TMO_CYC:
    - Pulse o_timeout, clear full[rd_ptr], toggle rd_ptr, release grant → IDLE.
    - o_line_rd_done is not pulsed and o_line_idx is unchanged.
  - Undefined: no watchdog; o_timeout tied to 0; READ waits indefinitely.

Decomposition:
- Package cnn_sched_pkg holds:
  - The sched_state_e enum {IDLE, GRANT, READ, DONE}.
  - REQ_CPU=0 and REQ_LCD=1.
  - Type line_cnt_t.
- One sub-module, rr_arb2: a 2-way round-robin arbiter with a last-grant register, updated on a DONE strobe.

Test Plan:
- Single line, CPU only, LINE_WORDS=8: i_line_done, then i_req=01 with ready held high → o_gnt=01, 8 o_rd_en pulses on o_rd_sel=0, o_line_rd_done, o_line_idx=1, o_wr_sel=1.
- Tie after reset: i_req=11 with two lines full → first line granted to CPU, second to LCD, rd_sel sequence 0, 1.
- Overflow: no reader, 4 i_line_done pulses → o_wr_allow=0 after the 2nd, o_drop_cnt=2; then read one line → o_wr_allow=1 and wr_sel points at the freed buffer.
- Back-pressure: toggle i_rd_ready 1/0 every cycle, empty flag asserted for 3 cycles → exactly LINE_WORDS pops, with no o_rd_en while empty or not ready.
- Frame start mid-READ with the other buffer full → the current line completes, the other buffer is cleared, o_line_idx = 0 then 1.
- LINE_TIMEOUT_EN with TMO_CYC=16: grant then ready=0 for 16 cycles → o_timeout pulse, grant released, no o_line_rd_done.
